// File: rtl/debouncer.sv
// Button/switch debouncer: a four-state FSM qualifies a synchronized input level over
// STABLE_TICKS rising edges of the DIV_CLK strobe. Define DEBOUNCER_IN_SYNC_EN for a 2-flop IN sync.
module debouncer #(
    parameter int unsigned STABLE_TICKS = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IN,
    input  logic       DIV_CLK,
    output logic       OUT,
    output logic [1:0] STATEVAL,
    output logic [4:0] FREQVAL,
    output logic       COUNT_RES,
    output logic       POS_IN
);

    typedef enum logic [1:0] {
        StIdleLow  = 2'd0,
        StWaitHigh = 2'd1,
        StIdleHigh = 2'd2,
        StWaitLow  = 2'd3
    } state_e;

    localparam logic [4:0] LastCnt = 5'(STABLE_TICKS - 1);

    logic   r_div_s1, r_div_s2, r_div_prev;
    logic   r_vld_s1, r_vld_s2, r_tick_armed;
    logic   r_pos_in;
    logic   w_tick;

    state_e     r_state, w_state_nxt;
    logic [4:0] r_cnt, w_cnt_nxt;
    logic       r_out, w_out_nxt;
    logic       r_cres, w_cres_nxt;

    // The detector is armed only after a real low sample of DIV_CLK, so a strobe that is
    // already high when reset releases does not count as a rising edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_div_s1     <= 1'b0;
            r_div_s2     <= 1'b0;
            r_div_prev   <= 1'b0;
            r_vld_s1     <= 1'b0;
            r_vld_s2     <= 1'b0;
            r_tick_armed <= 1'b0;
        end else begin
            r_div_s1     <= DIV_CLK;
            r_div_s2     <= r_div_s1;
            r_div_prev   <= r_div_s2;
            r_vld_s1     <= 1'b1;
            r_vld_s2     <= r_vld_s1;
            r_tick_armed <= r_tick_armed | (r_vld_s2 & ~r_div_s2);
        end
    end

    assign w_tick = r_tick_armed & r_div_s2 & ~r_div_prev;

`ifdef DEBOUNCER_IN_SYNC_EN
    logic r_in_s1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_in_s1  <= 1'b0;
            r_pos_in <= 1'b0;
        end else begin
            r_in_s1  <= IN;
            r_pos_in <= r_in_s1;
        end
    end
`else
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pos_in <= 1'b0;
        end else begin
            r_pos_in <= IN;
        end
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= StIdleLow;
            r_cnt   <= 5'd0;
            r_out   <= 1'b0;
            r_cres  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_cres  <= w_cres_nxt;
        end
    end

    // A bounce in a WAIT state has priority over a coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cres_nxt  = 1'b0;
        unique case (r_state)
            StIdleLow: begin
                if (r_pos_in) begin
                    w_state_nxt = StWaitHigh;
                    w_cnt_nxt   = 5'd0;
                end
            end
            StWaitHigh: begin
                if (!r_pos_in) begin
                    w_state_nxt = StIdleLow;
                    w_cnt_nxt   = 5'd0;
                    w_cres_nxt  = 1'b1;
                end else if (w_tick) begin
                    if (r_cnt == LastCnt) begin
                        w_state_nxt = StIdleHigh;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
            end
            StIdleHigh: begin
                if (!r_pos_in) begin
                    w_state_nxt = StWaitLow;
                    w_cnt_nxt   = 5'd0;
                end
            end
            StWaitLow: begin
                if (r_pos_in) begin
                    w_state_nxt = StIdleHigh;
                    w_cnt_nxt   = 5'd0;
                    w_cres_nxt  = 1'b1;
                end else if (w_tick) begin
                    if (r_cnt == LastCnt) begin
                        w_state_nxt = StIdleLow;
                        w_cnt_nxt   = 5'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdleLow;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    always_comb begin
        w_out_nxt = (w_state_nxt == StIdleHigh) || (w_state_nxt == StWaitLow);
    end

    assign OUT       = r_out;
    assign STATEVAL  = r_state;
    assign FREQVAL   = r_cnt;
    assign COUNT_RES = r_cres;
    assign POS_IN    = r_pos_in;

endmodule

// File: tb/tb_debouncer.sv
// Randomized self-checking bench for debouncer against a level/counter reference model.
module tb_debouncer;

    localparam int unsigned ST = 4;
`ifdef DEBOUNCER_IN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_in;
    logic       div;
    logic       dut_out;
    logic [1:0] dut_state;
    logic [4:0] dut_freq;
    logic       dut_cres;
    logic       dut_pos;

    debouncer #(.STABLE_TICKS(ST)) u_dut (
        .CLK      (clk),
        .RESET    (rst),
        .IN       (tb_in),
        .DIV_CLK  (div),
        .OUT      (dut_out),
        .STATEVAL (dut_state),
        .FREQVAL  (dut_freq),
        .COUNT_RES(dut_cres),
        .POS_IN   (dut_pos)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: debounced level, pending flag and tick count since the last change.
    int   m_out, m_pend, m_cnt, m_cres, m_pos, m_e;
    logic dq[$];
    logic iq[$];

    task automatic model_reset();
        m_out = 0; m_pend = 0; m_cnt = 0; m_cres = 0; m_pos = 0; m_e = 0;
        dq.delete();
        iq.delete();
    endtask

    // d[idx] where idx may be the edge currently being driven.
    function automatic logic d_at(input int idx, input logic cur);
        return (idx == m_e) ? cur : dq[idx];
    endfunction

    // A tick takes effect at edge E when DIV_CLK was sampled 0 at E-3 and 1 at E-2.
    function automatic bit tick_at(input int e, input logic cur);
        if (e < 3) return 0;
        return d_at(e - 2, cur) && !d_at(e - 3, cur);
    endfunction

    task automatic model_edge(input logic in_v, input logic div_v);
        bit tick;
        int pos_pre;
        tick   = tick_at(m_e, div_v);
        pos_pre = m_pos;
        m_cres = 0;
        if (m_pend == 0) begin
            if (pos_pre != m_out) begin
                m_pend = 1;
                m_cnt  = 0;
            end
        end else if (pos_pre == m_out) begin
            m_pend = 0;
            m_cnt  = 0;
            m_cres = 1;
        end else if (tick) begin
            if (m_cnt == int'(ST) - 1) begin
                m_out  = pos_pre;
                m_pend = 0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
            end
        end
        dq.push_back(div_v);
        iq.push_back(in_v);
        if (LAT == 1) m_pos = int'(in_v);
        else m_pos = (m_e >= 1) ? int'(iq[m_e - 1]) : 0;
        m_e++;
    endtask

    int div_hi = 4;
    int div_lo = 4;
    int div_ph = 0;

    task automatic next_div(output logic v);
        v = (div_ph >= div_lo);
        div_ph++;
        if (div_ph >= div_lo + div_hi) div_ph = 0;
    endtask

    task automatic compare_all();
        check_eq("OUT", int'(dut_out), m_out);
        check_eq("STATEVAL", int'(dut_state), m_out * 2 + m_pend);
        check_eq("FREQVAL", int'(dut_freq), m_cnt);
        check_eq("COUNT_RES", int'(dut_cres), m_cres);
        check_eq("POS_IN", int'(dut_pos), m_pos);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic drive(input logic in_v, input logic dv);
        tb_in = in_v;
        div   = dv;
        if (rst) model_reset();
        else model_edge(in_v, dv);
        @(negedge clk);
        compare_all();
    endtask

    task automatic cycle(input logic in_v);
        logic dv;
        next_div(dv);
        drive(in_v, dv);
    endtask

    task automatic check_async_zero(input string tag);
        check_eq({tag, "_OUT"}, int'(dut_out), 0);
        check_eq({tag, "_STATE"}, int'(dut_state), 0);
        check_eq({tag, "_FREQ"}, int'(dut_freq), 0);
        check_eq({tag, "_CRES"}, int'(dut_cres), 0);
        check_eq({tag, "_POS"}, int'(dut_pos), 0);
    endtask

    // Assert reset between clock edges, hold it with IN toggling, release with DIV_CLK at div_lvl.
    task automatic apply_reset(input string tag, input int n, input logic div_lvl);
        rst = 1'b1;
        #1;
        check_async_zero(tag);
        for (int i = 0; i < n; i++) cycle(logic'(i[0]));
        div_ph = div_lvl ? div_lo : 0;
        rst = 1'b0;
    endtask

    logic lvl;
    logic dv;
    bit   hit;
    int   len;

    initial begin
        rst   = 1'b1;
        tb_in = 1'b0;
        div   = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset("rst_init", 10, 1'b0);

        for (int i = 0; i < 6; i++) cycle(1'b0);
        lvl = 1'b0;
        for (int t = 0; t < 30; t++) begin
            lvl = ~lvl;
            for (int k = 0; k < 3; k++) cycle(lvl);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0);
        check_eq("bounce_out_low", int'(dut_out), 0);

        for (int i = 0; i < 60; i++) cycle(1'b1);
        check_eq("hold_high_out", int'(dut_out), 1);

        lvl = 1'b1;
        for (int t = 0; t < 26; t++) begin
            lvl = ~lvl;
            for (int k = 0; k < 3; k++) cycle(lvl);
            check_eq("bounce_out_high", int'(dut_out), 1);
        end
        for (int i = 0; i < 60; i++) cycle(1'b0);
        check_eq("hold_low_out", int'(dut_out), 0);

        // Drop IN so the bounce reaches the FSM on the same edge as the final tick.
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            next_div(dv);
            if (m_pend == 1 && m_out == 0 && m_cnt == int'(ST) - 1
                && tick_at(m_e + LAT, dv)) begin
                hit = 1;
                drive(1'b0, dv);
            end else begin
                drive(1'b1, dv);
            end
        end
        check_eq("abort_on_tick_found", int'(hit), 1);
        for (int i = 0; i < 20; i++) cycle(1'b0);
        check_eq("abort_on_tick_out", int'(dut_out), 0);

        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            cycle(1'b1);
            if (m_pend == 1 && m_out == 0 && m_cnt == 2) hit = 1;
        end
        check_eq("wait_cnt2_found", int'(hit), 1);
        apply_reset("rst_mid_wait", 4, 1'b1);
        for (int i = 0; i < 60; i++) cycle(1'b1);

        for (int seg = 0; seg < 5; seg++) begin
            div_hi = int'($urandom_range(1, 6));
            div_lo = int'($urandom_range(1, 6));
            div_ph = 0;
            for (int n = 0; n < 600; ) begin
                lvl = logic'($urandom_range(0, 1));
                len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 80))
                                                  : int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) cycle(lvl);
                n += len;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 SHALL have parameter: STABLE_TICKS, default 4, number of consecutive stable DIV_CLK ticks required before OUT changes; legal range 1..31.
REQ-002 SHALL have port: CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: IN  input  1  raw, bouncing, asynchronous button/switch level.
REQ-005 SHALL have port: DIV_CLK  input  1  slow sampling strobe, treated as data and never used as a clock.
REQ-006 SHALL have port: OUT  output  1  debounced level, registered.
REQ-007 SHALL have port: STATEVAL  output  2  current FSM state encoding.
REQ-008 SHALL have port: FREQVAL  output  5  current stable-tick counter value.
REQ-009 SHALL have port: COUNT_RES  output  1  one-CLK pulse when a pending transition is aborted by a bounce.
REQ-010 SHALL have port: POS_IN  output  1  synchronized copy of IN used by the FSM.

Function
REQ-011 SHALL synchronize DIV_CLK through two CLK flops, then generate internal tick for one CLK cycle when the synchronized value is 1 and its previous value was 0.
REQ-012 SHALL derive POS_IN from IN per REQ-024/REQ-025; the FSM uses only POS_IN.
REQ-013 SHALL implement four states: IDLE_LOW=0, WAIT_HIGH=1, IDLE_HIGH=2, WAIT_LOW=3, driven on STATEVAL.
REQ-014 In IDLE_LOW: OUT=0, FREQVAL=0; POS_IN=1 -> WAIT_HIGH with FREQVAL=0.
REQ-015 In WAIT_HIGH: POS_IN=0 -> IDLE_LOW, FREQVAL=0, COUNT_RES=1 next cycle; else on tick FREQVAL increments by 1.
REQ-016 In WAIT_HIGH: tick with FREQVAL=STABLE_TICKS-1 and POS_IN=1 -> IDLE_HIGH, OUT=1 and FREQVAL=0 on that same edge.
REQ-017 IDLE_HIGH and WAIT_LOW SHALL mirror REQ-014..016 with polarities swapped; OUT=0 on entry to IDLE_LOW from WAIT_LOW.
REQ-018 Simultaneous tick and bounce in a WAIT state: bounce wins; state returns to IDLE, FREQVAL=0, COUNT_RES pulses.
REQ-019 Ticks in IDLE states SHALL be ignored; FREQVAL never exceeds STABLE_TICKS-1 and never wraps.
REQ-020 COUNT_RES SHALL be registered, high exactly one CLK cycle per abort, 0 otherwise.
REQ-021 OUT SHALL change only on entry to IDLE_HIGH/IDLE_LOW; latency from stable POS_IN = time to STABLE_TICKS ticks plus 1 CLK.

Reset
REQ-022 RESET=1 SHALL immediately force STATEVAL=0, OUT=0, FREQVAL=0, COUNT_RES=0, POS_IN=0, tick-detector and synchronizer flops=0, regardless of CLK.
REQ-023 After RESET deasserts, the first rising DIV_CLK edge SHALL produce a tick; a DIV_CLK already high at release SHALL NOT.

Configuration
REQ-024 With macro DEBOUNCER_IN_SYNC_EN defined, POS_IN SHALL be IN passed through two CLK flops (2-cycle latency).
REQ-025 Without DEBOUNCER_IN_SYNC_EN, POS_IN SHALL be IN registered once (1-cycle latency); all other behaviour unchanged.

Verification (STABLE_TICKS=4, DIV_CLK period 8 CLK cycles, macro defined)
REQ-026 RESET=1 for 10 cycles with IN toggling -> OUT=0, STATEVAL=0, FREQVAL=0, COUNT_RES=0, POS_IN=0 throughout.
REQ-027 IN=0->1 toggling every 3 CLK for 30 toggles -> OUT stays 0, STATEVAL alternates 0/1, COUNT_RES pulses per abort, FREQVAL never reaches 3 before returning to 0.
REQ-028 IN held 1 -> FREQVAL counts 0,1,2,3 on ticks; 4th tick -> STATEVAL=2, OUT=1, FREQVAL=0.
REQ-029 From OUT=1, 26 toggles every 3 CLK then IN held 0 -> OUT stays 1 during bounce, OUT=0 and STATEVAL=0 after 4 stable ticks.
REQ-030 RESET asserted mid-WAIT_HIGH with FREQVAL=2 -> STATEVAL=0, FREQVAL=0, OUT=0 without waiting for CLK.
REQ-031 Bounce coinciding with tick in WAIT_HIGH, FREQVAL=3 -> STATEVAL=0, FREQVAL=0, OUT=0, COUNT_RES=1 for one cycle.
